// File: rtl/unary_mac_sched_pkg.sv
// Shared types and constants for the unary MAC scheduler.
package unary_mac_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

    // Default watchdog limit in WAIT cycles.
    localparam int DEFAULT_TIMEOUT = 64;

    // Width of the WAIT-cycle counter; it only needs to reach TIMEOUT-1.
    function automatic int cnt_width(input int timeout);
        if (timeout > 2) begin
            return $clog2(timeout);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first request at or after ptr,
// wrapping modulo N, and reports it both one-hot and as a binary index.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found_s;

    // Two-pass priority search: [ptr..N-1] first, then the wrapped part [0..ptr-1].
    always_comb begin
        found_s = 1'b0;
        idx     = '0;
        gnt     = '0;
        for (int j = 0; j < N; j++) begin
            if (!found_s && req[j] && (j >= int'(ptr))) begin
                found_s = 1'b1;
                idx     = PW'(j);
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found_s && req[j] && (j < int'(ptr))) begin
                found_s = 1'b1;
                idx     = PW'(j);
            end else begin
                found_s = found_s;
            end
        end
        for (int j = 0; j < N; j++) begin
            gnt[j] = found_s && (idx == PW'(j));
        end
    end

endmodule

// File: rtl/unary_mac_scheduler.sv
// Shares one unary/binary MAC between NUM_REQ requesters with round-robin
// arbitration, a stale-completion guard and a completion watchdog.
module unary_mac_scheduler
    import unary_mac_sched_pkg::*;
#(
    parameter int SIZE    = 4,
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*SIZE-1:0] req_a,
    input  logic [NUM_REQ*SIZE-1:0] req_b,
    input  logic [NUM_REQ*SIZE-1:0] req_c,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [2*SIZE-1:0]       rsp_data,
    output logic                    rsp_err,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic                    mac_valid,
    output logic [SIZE-1:0]         mac_a,
    output logic [SIZE-1:0]         mac_b,
    output logic [SIZE-1:0]         mac_c,
    input  logic                    mac_ready,
    input  logic [2*SIZE-1:0]       mac_out
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = cnt_width(TIMEOUT);
    localparam int DW = 2 * SIZE;

    sched_state_t        state_q;
    logic [PW-1:0]       ptr_q;
    logic [PW-1:0]       ptr_d;
    logic [PW-1:0]       gidx_q;
    logic [PW-1:0]       gidx_s;
    logic [NUM_REQ-1:0]  gnt_s;
    logic [SIZE-1:0]     a_q;
    logic [SIZE-1:0]     b_q;
    logic [SIZE-1:0]     c_q;
    logic [CW-1:0]       cnt_q;
    logic                first_q;
    logic                mac_valid_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic [DW-1:0]       rsp_data_q;
    logic                rsp_err_q;
    logic                mac_done_s;
    logic                timeout_s;
    logic                rsp_hs_s;
    logic [NUM_REQ-1:0]  gnt_oh_s;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt_s),
        .idx (gidx_s)
    );

    // Accept is combinational so the requester sees it in the grant cycle.
    assign req_ready  = (state_q == IDLE) ? gnt_s : '0;
    assign mac_valid  = mac_valid_q;
    assign mac_a      = a_q;
    assign mac_b      = b_q;
    assign mac_c      = c_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;

    // The first WAIT cycle may carry a completion left over from before the start.
    assign mac_done_s = mac_ready && !first_q;
    assign timeout_s  = (cnt_q == CW'(TIMEOUT - 1));
    assign rsp_hs_s   = rsp_ready[gidx_q];
    assign gnt_oh_s   = NUM_REQ'(1) << gidx_q;

    // Next round-robin pointer: the requester after the one just served.
    always_comb begin
        if (gidx_q == PW'(NUM_REQ - 1)) begin
            ptr_d = '0;
        end else begin
            ptr_d = gidx_q + PW'(1);
        end
    end

    // Scheduler FSM with all registered outputs and operand capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gidx_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            mac_valid_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        gidx_q      <= gidx_s;
                        a_q         <= req_a[gidx_s*SIZE +: SIZE];
                        b_q         <= req_b[gidx_s*SIZE +: SIZE];
                        c_q         <= req_c[gidx_s*SIZE +: SIZE];
                        mac_valid_q <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mac_valid_q <= 1'b0;
                    cnt_q       <= '0;
                    first_q     <= 1'b1;
                    state_q     <= WAIT;
                end
                WAIT: begin
                    first_q <= 1'b0;
                    if (mac_done_s) begin
                        rsp_data_q  <= mac_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= gnt_oh_s;
                        state_q     <= RESP;
                    end else if (timeout_s) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= gnt_oh_s;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    if (rsp_hs_s) begin
                        rsp_valid_q <= '0;
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b0;
                        ptr_q       <= ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unary_mac_scheduler.sv
// Scoreboard bench for unary_mac_scheduler with a behavioural MAC model.
module tb_unary_mac_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req_valid;
    logic [15:0] req_a, req_b, req_c;
    logic [3:0]  req_ready, rsp_valid, rsp_ready;
    logic [7:0]  rsp_data;
    logic        rsp_err;
    logic        mac_valid, mac_ready;
    logic [3:0]  mac_a, mac_b, mac_c;
    logic [7:0]  mac_out;

    typedef struct packed {
        logic [3:0] oh;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] exp_tab [4];
    int         total = 0;
    int         bad = 0;
    int         mac_mode = 0;   // 0 normal, 1 stale pulse first, 2 never completes
    localparam int MAC_LAT = 4;

    unary_mac_scheduler #(.SIZE(4), .NUM_REQ(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready),
        .mac_valid(mac_valid), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
        .mac_ready(mac_ready), .mac_out(mac_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        req_a[i*4 +: 4] = a;
        req_b[i*4 +: 4] = b;
        req_c[i*4 +: 4] = c;
    endtask

    task automatic push_exp(input int i, input logic [7:0] d, input logic e);
        exp_t x;
        x.oh   = 4'b0001 << i;
        x.data = d;
        x.err  = e;
        sb_q.push_back(x);
    endtask

    // Raise the requests in mask, check grants against order (2 bits per grant),
    // push the expected response per grant and drop each request once accepted.
    task automatic serve(input logic [3:0] mask, input int n, input logic [7:0] order, input logic err_exp);
        int k;
        int cyc;
        int g;
        k = 0;
        cyc = 0;
        @(posedge clk); #1;
        req_valid = req_valid | mask;
        while (k < n && cyc < 400) begin
            #1;
            if (req_ready != 4'b0000) begin
                g = 0;
                for (int j = 0; j < 4; j++) if (req_ready[j]) g = j;
                check("grant_order", g, order[2*k +: 2]);
                check("req_ready_onehot", $countones(req_ready), 1);
                push_exp(g, err_exp ? 8'd0 : exp_tab[g], err_exp);
                k++;
                @(posedge clk); #1;
                req_valid[g] = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
            cyc++;
        end
        if (k < n) begin
            total++; bad++;
            $display("FAIL grant_timeout: got %0d grants, expected %0d", k, n);
        end
    endtask

    task automatic wait_drain(input int max_cyc);
        int cyc;
        cyc = 0;
        while (sb_q.size() != 0 && cyc < max_cyc) begin
            @(posedge clk);
            cyc++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 4'b0000);
        check({tag, "_rsp_data"}, rsp_data, 8'd0);
        check({tag, "_rsp_err"}, rsp_err, 1'b0);
        check({tag, "_mac_valid"}, mac_valid, 1'b0);
        check({tag, "_mac_a"}, mac_a, 4'd0);
        check({tag, "_mac_b"}, mac_b, 4'd0);
        check({tag, "_mac_c"}, mac_c, 4'd0);
        check({tag, "_req_ready"}, req_ready, 4'b0000);
    endtask

    // Behavioural MAC: completes MAC_LAT cycles after start; optionally emits a stale pulse.
    initial begin
        logic [3:0] ma, mb, mc;
        int  cnt;
        bit  busy;
        ma = 4'd0; mb = 4'd0; mc = 4'd0;
        cnt = 0; busy = 1'b0;
        mac_ready = 1'b0;
        mac_out = 8'd0;
        forever begin
            @(posedge clk); #2;
            mac_ready = 1'b0;
            mac_out = 8'd0;
            if (mac_valid === 1'b1) begin
                ma = mac_a; mb = mac_b; mc = mac_c;
                busy = 1'b1;
                cnt = 0;
            end else if (busy) begin
                cnt++;
                if (mac_mode == 1 && cnt == 1) begin
                    mac_ready = 1'b1;
                    mac_out = 8'hAA;
                end
                if (mac_mode != 2 && cnt == MAC_LAT) begin
                    mac_ready = 1'b1;
                    mac_out = {4'd0, ma} * {4'd0, mb} + {4'd0, mc};
                    busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && (rsp_valid & rsp_ready) != 4'b0000) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid=%b, expected none", rsp_valid);
                end else begin
                    e = sb_q.pop_front();
                    check("rsp_valid", rsp_valid, e.oh);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_err", rsp_err, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        reset = 1'b1;
        req_valid = 4'b0000;
        req_a = 16'd0; req_b = 16'd0; req_c = 16'd0;
        rsp_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;

        // All four at once from pointer 0: order 0,1,2,3.
        set_ops(0, 4'd1, 4'd2, 4'd3);    exp_tab[0] = 8'd5;
        set_ops(1, 4'd4, 4'd4, 4'd1);    exp_tab[1] = 8'd17;
        set_ops(2, 4'd7, 4'd3, 4'd0);    exp_tab[2] = 8'd21;
        set_ops(3, 4'd15, 4'd15, 4'd15); exp_tab[3] = 8'd240;
        serve(4'b1111, 4, 8'b11_10_01_00, 1'b0);
        wait_drain(1000);

        // Pointer wrapped to 0: requester 0 beats requester 2.
        set_ops(0, 4'd5, 4'd5, 4'd5);    exp_tab[0] = 8'd30;
        set_ops(2, 4'd6, 4'd2, 4'd1);    exp_tab[2] = 8'd13;
        serve(4'b0101, 2, 8'b0000_10_00, 1'b0);
        wait_drain(500);

        // Single request from requester 1, with MAC start timing.
        set_ops(1, 4'd3, 4'd5, 4'd2);    exp_tab[1] = 8'd17;
        serve(4'b0010, 1, 8'd1, 1'b0);
        #1;
        check("mac_valid_issue", mac_valid, 1'b1);
        check("mac_a", mac_a, 4'd3);
        check("mac_b", mac_b, 4'd5);
        check("mac_c", mac_c, 4'd2);
        @(posedge clk); #2;
        check("mac_valid_one_cycle", mac_valid, 1'b0);
        check("mac_a_stable", mac_a, 4'd3);
        wait_drain(200);

        // Backpressure on requester 2 with requester 0 pending.
        rsp_ready = 4'b1011;
        set_ops(2, 4'd7, 4'd3, 4'd0);    exp_tab[2] = 8'd21;
        serve(4'b0100, 1, 8'd2, 1'b0);
        n = 0;
        while (rsp_valid[2] !== 1'b1 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        check("bp_rsp_seen", rsp_valid[2], 1'b1);
        set_ops(0, 4'd2, 4'd3, 4'd1);    exp_tab[0] = 8'd7;
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("bp_rsp_valid", rsp_valid, 4'b0100);
            check("bp_rsp_data", rsp_data, 8'd21);
            check("bp_req_ready", req_ready, 4'b0000);
            check("bp_mac_valid", mac_valid, 1'b0);
            @(posedge clk); #1;
        end
        rsp_ready = 4'b1111;
        serve(4'b0001, 1, 8'd0, 1'b0);
        wait_drain(200);

        // Stale completion pulse in the first WAIT cycle must be ignored.
        mac_mode = 1;
        set_ops(3, 4'd15, 4'd15, 4'd15); exp_tab[3] = 8'd240;
        serve(4'b1000, 1, 8'd3, 1'b0);
        wait_drain(200);
        mac_mode = 0;

        // Watchdog: MAC never completes.
        mac_mode = 2;
        set_ops(1, 4'd1, 4'd1, 4'd1);
        serve(4'b0010, 1, 8'd1, 1'b1);
        #1;
        check("to_mac_valid", mac_valid, 1'b1);
        n = 0;
        while (rsp_valid === 4'b0000 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("timeout_latency", n, 65);
        wait_drain(50);
        mac_mode = 0;
        set_ops(2, 4'd2, 4'd5, 4'd3);    exp_tab[2] = 8'd13;
        serve(4'b0100, 1, 8'd2, 1'b0);
        wait_drain(200);

        // Asynchronous reset in the middle of WAIT.
        set_ops(0, 4'd9, 4'd9, 4'd9);
        @(posedge clk); #1;
        req_valid = 4'b0001;
        #1;
        check("rst_pre_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = 4'b0000;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        set_ops(0, 4'd2, 4'd2, 4'd0);    exp_tab[0] = 8'd4;
        serve(4'b0001, 1, 8'd0, 1'b0);
        wait_drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
